imu_burst_reader: RTL



---
 rtl/imu_burst_reader_pkg.sv | 30 +++
 rtl/imu_spi_shifter.sv | 77 +++++++
 rtl/imu_burst_reader.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/imu_burst_reader_pkg.sv
// Shared types and constants for the IMU burst reader.
// Overrun counting in imu_burst_reader is enabled by defining IMU_BURST_OVERRUN_EN.
package imu_pkg;

    // Burst sequencer states, in the order a burst walks through them.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ADDR,
        ST_DATA,
        ST_HOLD,
        ST_GAP
    } state_t;

    // MSB of the address byte selects a register read on the IMU.
    localparam logic       IMU_READ_BIT   = 1'b1;
    // Clocked out on mosi while register bytes are read back.
    localparam logic [7:0] IMU_DUMMY_BYTE = 8'hFF;
    // Largest burst the IMU auto-increment window allows.
    localparam int         IMU_MAX_REGS   = 32;

    // Number of bits needed to hold the values 0..max_val (at least one bit).
    function automatic int bits_for(input int max_val);
        for (int w = 1; w < 32; w++) begin
            if ((1 << w) > max_val) return w;
        end
        return 32;
    endfunction

endpackage

// File: rtl/imu_spi_shifter.sv
// One-byte SPI mode-0 shifter: sck idles low, miso sampled on the rising
// edge, mosi updated on the falling edge, each sck phase lasts CLK_DIV clk
// cycles. A start in the final cycle of a byte chains the next byte with no
// gap, which keeps sck perfectly periodic across a burst.
module imu_spi_shifter
    import imu_pkg::*;
#(
    parameter int CLK_DIV = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] byte_in,
    input  logic       miso,
    output logic       sck,
    output logic       mosi,
    output logic       done,
    output logic [7:0] byte_out
);

    localparam int DW = bits_for(CLK_DIV - 1);

    logic          active;
    logic [DW-1:0] div_cnt;
    logic [2:0]    bit_cnt;
    logic [7:0]    tx_sr;
    logic [7:0]    rx_sr;
    logic          phase_end;

    assign phase_end = active && (div_cnt == DW'(CLK_DIV - 1));
    // High in the last cycle of the byte's final high phase; byte_out is complete here.
    assign done      = phase_end && sck && (bit_cnt == 3'd7);
    assign byte_out  = rx_sr;

    // Phase divider, sck toggling and the two shift registers.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the pre-edge values, independent of statement order.
        if (rst) begin
            active  <= 1'b0;
            sck     <= 1'b0;
            mosi    <= 1'b1;
            div_cnt <= '0;
            bit_cnt <= '0;
            tx_sr   <= 8'hFF;
            rx_sr   <= 8'h00;
        end else if (start && (!active || done)) begin
            active  <= 1'b1;
            sck     <= 1'b0;
            div_cnt <= '0;
            bit_cnt <= '0;
            tx_sr   <= byte_in;
            mosi    <= byte_in[7];
        end else if (active) begin
            if (phase_end) begin
                div_cnt <= '0;
                if (!sck) begin
                    sck   <= 1'b1;
                    rx_sr <= {rx_sr[6:0], miso};
                end else begin
                    sck <= 1'b0;
                    if (bit_cnt == 3'd7) begin
                        active <= 1'b0;
                        mosi   <= 1'b1;
                    end else begin
                        bit_cnt <= bit_cnt + 3'd1;
                        mosi    <= tx_sr[6];
                        tx_sr   <= {tx_sr[6:0], 1'b1};
                    end
                end
            end else begin
                div_cnt <= div_cnt + DW'(1);
            end
        end
    end

endmodule

// File: rtl/imu_burst_reader.sv
// IMU register burst reader: one read-address byte followed by NUM_REGS
// register bytes under a single chip-select window, published atomically
// on data with a one-cycle valid strobe.
// Define IMU_BURST_OVERRUN_EN to count ticks dropped while busy.
module imu_burst_reader
    import imu_pkg::*;
#(
    parameter int         NUM_REGS  = 6,
    parameter logic [6:0] BASE_ADDR = 7'h3B,
    parameter int         CLK_DIV   = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  tick,
    input  logic                  spi_miso,
    output logic                  spi_sck,
    output logic                  spi_mosi,
    output logic                  spi_cs_n,
    output logic                  busy,
    output logic                  valid,
    output logic [8*NUM_REGS-1:0] data,
    output logic [7:0]            overrun_cnt
);

    localparam int         CW        = bits_for(CLK_DIV);
    localparam int         BW        = bits_for(NUM_REGS - 1);
    localparam int         DATA_W    = 8 * NUM_REGS;
    localparam logic [7:0] ADDR_BYTE = {IMU_READ_BIT, BASE_ADDR};

    state_t            state, state_d;
    logic [CW-1:0]     cnt, cnt_d;
    logic [BW-1:0]     byte_cnt, byte_cnt_d;
    logic              cs_n_d, busy_d, valid_d;
    logic              sh_start, sh_done;
    logic [7:0]        sh_byte_in, sh_byte_out;
    logic              shadow_we, load_data;
    logic [DATA_W-1:0] shadow;

    imu_spi_shifter #(
        .CLK_DIV (CLK_DIV)
    ) u_shifter (
        .clk      (clk),
        .rst      (rst),
        .start    (sh_start),
        .byte_in  (sh_byte_in),
        .miso     (spi_miso),
        .sck      (spi_sck),
        .mosi     (spi_mosi),
        .done     (sh_done),
        .byte_out (sh_byte_out)
    );

    // Burst state register and registered control outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            byte_cnt <= '0;
            spi_cs_n <= 1'b1;
            busy     <= 1'b0;
            valid    <= 1'b0;
        end else begin
            state    <= state_d;
            cnt      <= cnt_d;
            byte_cnt <= byte_cnt_d;
            spi_cs_n <= cs_n_d;
            busy     <= busy_d;
            valid    <= valid_d;
        end
    end

    // Next-state logic: phase timing, byte sequencing and shifter handshake.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // one unassigned, which would infer a latch.
        state_d    = state;
        cnt_d      = cnt;
        byte_cnt_d = byte_cnt;
        cs_n_d     = spi_cs_n;
        busy_d     = busy;
        valid_d    = 1'b0;
        sh_start   = 1'b0;
        sh_byte_in = IMU_DUMMY_BYTE;
        shadow_we  = 1'b0;
        load_data  = 1'b0;

        case (state)
            ST_IDLE: begin
                if (tick) begin
                    state_d = ST_SETUP;
                    cnt_d   = '0;
                    cs_n_d  = 1'b0;
                    busy_d  = 1'b1;
                end
            end
            ST_SETUP: begin
                // Launch the address byte so its first low phase follows directly.
                if (cnt == CW'(CLK_DIV - 1)) begin
                    sh_start   = 1'b1;
                    sh_byte_in = ADDR_BYTE;
                    state_d    = ST_ADDR;
                end else begin
                    cnt_d = cnt + CW'(1);
                end
            end
            ST_ADDR: begin
                // Byte clocked in during the address phase is not stored.
                if (sh_done) begin
                    sh_start   = 1'b1;
                    state_d    = ST_DATA;
                    byte_cnt_d = '0;
                end
            end
            ST_DATA: begin
                if (sh_done) begin
                    shadow_we = 1'b1;
                    if (byte_cnt == BW'(NUM_REGS - 1)) begin
                        state_d = ST_HOLD;
                        cnt_d   = '0;
                    end else begin
                        sh_start   = 1'b1;
                        byte_cnt_d = byte_cnt + BW'(1);
                    end
                end
            end
            ST_HOLD: begin
                if (cnt == CW'(CLK_DIV - 1)) begin
                    state_d   = ST_GAP;
                    cnt_d     = '0;
                    cs_n_d    = 1'b1;
                    valid_d   = 1'b1;
                    load_data = 1'b1;
                end else begin
                    cnt_d = cnt + CW'(1);
                end
            end
            ST_GAP: begin
                // Valid cycle plus CLK_DIV idle cycles with chip select high.
                if (cnt == CW'(CLK_DIV)) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end else begin
                    cnt_d = cnt + CW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Shadow buffer: the first register read lands in the most significant byte.
    always_ff @(posedge clk) begin
        // NOTE: the shadow buffer has no reset; every slot is rewritten before
        // it can be published, and an aborted burst never reaches data.
        if (!rst && shadow_we) begin
            shadow[(NUM_REGS - 1 - int'(byte_cnt)) * 8 +: 8] <= sh_byte_out;
        end
    end

    // Published result changes only in the valid cycle, all bytes at once.
    always_ff @(posedge clk) begin
        if (rst) begin
            data <= '0;
        end else if (load_data) begin
            data <= shadow;
        end
    end

`ifdef IMU_BURST_OVERRUN_EN
    // Saturating count of ticks that arrived while a burst was in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            overrun_cnt <= 8'h00;
        end else if (tick && busy && (overrun_cnt != 8'hFF)) begin
            overrun_cnt <= overrun_cnt + 8'h01;
        end
    end
`else
    assign overrun_cnt = 8'h00;
`endif

endmodule
